// File: rtl/regdump_streamer.sv
// regdump_streamer: on dump_req, streams the PC and then $s0-$s7 and $t0-$t9 as tagged valid/ready words.
// Optional feature macro REGDUMP_CHECKSUM_EN appends an XOR checksum word (tag 19) to every dump.
module regdump_streamer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Handshake: a word transfers on every rising edge where out_valid && out_ready are both high;
    // while out_valid=1 and out_ready=0, out_data, out_tag and out_last are held unchanged.

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_PC  = 3'd1,
        FETCH    = 3'd2,
        SEND_REG = 3'd3,
        DONE     = 3'd4,
        SEND_SUM = 3'd5
    } state_t;
    localparam logic [TAG_W-1:0] SUM_TAG = TAG_W'(19);
`else
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_PC  = 3'd1,
        FETCH    = 3'd2,
        SEND_REG = 3'd3,
        DONE     = 3'd4
    } state_t;
`endif

    localparam logic [TAG_W-1:0] FIRST_IDX = TAG_W'(1);
    localparam logic [TAG_W-1:0] LAST_IDX  = TAG_W'(18);

    state_t            state;
    logic [TAG_W-1:0]  idx;

    // Word index to register number: 1-8 -> r16-r23 ($s), 9-16 -> r8-r15 ($t0-$t7), 17-18 -> r24-r25.
    function automatic logic [ADDR_W-1:0] reg_addr(input logic [TAG_W-1:0] i);
        logic [TAG_W-1:0] a;
        if (i <= TAG_W'(8))
            a = i + TAG_W'(15);
        else if (i <= TAG_W'(16))
            a = i - TAG_W'(1);
        else
            a = i + TAG_W'(7);
        return ADDR_W'(a);
    endfunction

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (state == IDLE && dump_req)
            acc <= '0;
        else if (out_valid && out_ready)
            acc <= acc ^ out_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        out_data  <= pc_in;
                        out_tag   <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND_PC;
                    end
                end
                SEND_PC: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= FIRST_IDX;
                        rf_raddr  <= reg_addr(FIRST_IDX);
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // rf_rdata is sampled here, so pipeline writes before this edge are visible.
                    out_data  <= rf_rdata;
                    out_tag   <= idx;
                    out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= (idx == LAST_IDX);
`endif
                    state     <= SEND_REG;
                end
                SEND_REG: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // acc does not yet include the $t9 word accepted at this edge.
                            out_data  <= acc ^ out_data;
                            out_tag   <= SUM_TAG;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            state     <= SEND_SUM;
`else
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            idx      <= idx + TAG_W'(1);
                            rf_raddr <= reg_addr(idx + TAG_W'(1));
                            state    <= FETCH;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                SEND_SUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regdump_streamer.sv
// Bench for regdump_streamer: scenario table, randomized dumps and directed corner sequences.
// Honours REGDUMP_CHECKSUM_EN to expect the trailing checksum word.
module tb_regdump_streamer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int TAG_W  = 5;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int LEN      = 20;
    localparam int FULL_CYC = 39;
`else
    localparam int LEN      = 19;
    localparam int FULL_CYC = 38;
`endif
    localparam int ORDER [18] = '{16, 17, 18, 19, 20, 21, 22, 23,
                                  8, 9, 10, 11, 12, 13, 14, 15, 24, 25};
    localparam logic [DATA_W-1:0] TEST_PC = 32'h0040_0020;

    logic              clk;
    logic              reset;
    logic              dump_req;
    logic [DATA_W-1:0] pc_in;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_last;
    logic              busy;
    logic              done;

    regdump_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .dump_req(dump_req), .pc_in(pc_in),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last), .busy(busy), .done(done)
    );

    logic [DATA_W-1:0] rf [32];
    assign rf_rdata = rf[rf_raddr];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- ready driver ----------------
    int ready_mode = 0;  // 0: always, 1: one cycle in three, 2: random
    int rdy_cnt    = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rdy_cnt % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [DATA_W-1:0] got_data [$];
    logic [TAG_W-1:0]  got_tag  [$];
    logic              got_last [$];
    logic [DATA_W-1:0] exp_q    [$];
    int                done_count = 0;
    bit                stall_prev = 0;
    bit                done_prev  = 0;
    logic [DATA_W-1:0] prev_data;
    logic [TAG_W-1:0]  prev_tag;
    logic              prev_last;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
            done_prev  = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_tag", out_tag, prev_tag);
                check("stall_last", out_last, prev_last);
            end
            if (done_prev) check("done_one_cycle", done, 0);
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_tag.push_back(out_tag);
                got_last.push_back(out_last);
            end
            if (done) done_count++;
            stall_prev = out_valid && !out_ready;
            done_prev  = done;
            prev_data  = out_data;
            prev_tag   = out_tag;
            prev_last  = out_last;
        end
    end

    // ---------------- reference model ----------------
    task automatic fill_rf(input bit rand_fill);
        for (int r = 0; r < 32; r++)
            rf[r] = rand_fill ? DATA_W'($urandom) : DATA_W'(32'h100 + r);
    endtask

    task automatic build_expected(input logic [DATA_W-1:0] pc, input int reps);
        logic [DATA_W-1:0] sum;
        exp_q.delete();
        for (int d = 0; d < reps; d++) begin
            exp_q.push_back(pc);
            sum = pc;
            for (int j = 0; j < 18; j++) begin
                exp_q.push_back(rf[ORDER[j]]);
                sum = sum ^ rf[ORDER[j]];
            end
`ifdef REGDUMP_CHECKSUM_EN
            exp_q.push_back(sum);
`endif
        end
    endtask

    task automatic compare_stream();
        check("word_count", got_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            check($sformatf("data[%0d]", i), got_data[i], exp_q[i]);
            check($sformatf("tag[%0d]", i), got_tag[i], i % LEN);
            check($sformatf("last[%0d]", i), got_last[i], (i % LEN) == LEN - 1);
        end
    endtask

    // ---------------- driver tasks ----------------
    int req_cyc = 0;

    // Returns at the falling edge after the edge that sampled dump_req.
    task automatic start_dump(input logic [DATA_W-1:0] pc);
        got_data.delete();
        got_tag.delete();
        got_last.delete();
        done_count = 0;
        @(posedge clk);
        #1;
        pc_in    = pc;
        dump_req = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        req_cyc  = cyc;
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("first_tag", out_tag, 0);
        check("first_data_pc", out_data, pc);
        check("busy_in_dump", busy, 1);
    endtask

    // Must be entered at a falling edge; n counts edges with the request edge as edge 1.
    task automatic wait_done(output int n);
        int guard = 0;
        while (!done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (done) begin
            n = cyc - req_cyc + 1;
        end else begin
            n = -1;
            check("done_timeout", 0, 1);
        end
    endtask

    task automatic post_done(input int exp_done);
        @(negedge clk);
        check("done_dropped", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        repeat (3) @(negedge clk);
        check("done_count", done_count, exp_done);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        logic [DATA_W-1:0] pc;
        int                ready_mode;
        bit                rand_fill;
        int                exp_cyc;
    } scen_t;

    scen_t scen [4];

    initial begin
        int n;
        int g;
        int done_n;
        int rises;
        int start2;
        bit prev_busy;

        scen[0].pc = TEST_PC;      scen[0].ready_mode = 0; scen[0].rand_fill = 0; scen[0].exp_cyc = FULL_CYC;
        scen[1].pc = TEST_PC;      scen[1].ready_mode = 1; scen[1].rand_fill = 0; scen[1].exp_cyc = -1;
        scen[2].pc = 32'hBFC0_0000; scen[2].ready_mode = 2; scen[2].rand_fill = 1; scen[2].exp_cyc = -1;
        scen[3].pc = 32'h8000_0180; scen[3].ready_mode = 0; scen[3].rand_fill = 1; scen[3].exp_cyc = FULL_CYC;

        reset    = 1'b1;
        dump_req = 1'b0;
        pc_in    = '0;
        fill_rf(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_raddr", rf_raddr, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int s = 0; s < 4; s++) begin
            ready_mode = scen[s].ready_mode;
            fill_rf(scen[s].rand_fill);
            start_dump(scen[s].pc);
            wait_done(n);
            if (scen[s].exp_cyc > 0) check($sformatf("cycles_to_done_s%0d", s), n, scen[s].exp_cyc);
            post_done(1);
            build_expected(scen[s].pc, 1);
            compare_stream();
            if (s == 0) begin
                check("lit_s0", got_data[1], 32'h110);
                check("lit_s7", got_data[8], 32'h117);
                check("lit_t0", got_data[9], 32'h108);
                check("lit_t7", got_data[16], 32'h10F);
                check("lit_t8", got_data[17], 32'h118);
                check("lit_t9", got_data[18], 32'h119);
            end
        end

        // Randomized dumps under random back-pressure.
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            logic [DATA_W-1:0] rpc;
            rpc = DATA_W'($urandom);
            fill_rf(1);
            start_dump(rpc);
            wait_done(n);
            post_done(1);
            build_expected(rpc, 1);
            compare_stream();
        end

        // dump_req held high for 50 cycles: one dump, then a restart right after DONE.
        ready_mode = 0;
        fill_rf(0);
        got_data.delete();
        got_tag.delete();
        got_last.delete();
        done_count = 0;
        done_n = -1;
        start2 = -1;
        rises = 0;
        prev_busy = 0;
        @(posedge clk);
        #1;
        pc_in    = TEST_PC;
        dump_req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done && done_n < 0) done_n = k;
            if (busy && !prev_busy) begin
                rises++;
                if (rises == 2) start2 = k;
            end
            prev_busy = busy;
        end
        #1 dump_req = 1'b0;
        check("held_done_cycle", done_n, FULL_CYC);
        check("held_restart_cycle", start2, FULL_CYC + 2);
        check("held_starts", rises, 2);
        @(negedge clk);
        wait_done(n);
        post_done(2);
        build_expected(TEST_PC, 2);
        compare_stream();

        // Pipeline write to r17 while idx=1 is visible in tag 2.
        ready_mode = 0;
        fill_rf(0);
        start_dump(TEST_PC);
        g = 0;
        while (!(out_valid && out_tag == 1) && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("wr_tag1_seen", out_tag, 1);
        rf[17] = 32'hDEAD_BEEF;
        wait_done(n);
        post_done(1);
        check("wr_tag2_data", got_data[2], 32'hDEAD_BEEF);
        check("wr_tag2_tag", got_tag[2], 2);
        build_expected(TEST_PC, 1);
        compare_stream();

        // Reset while tag 7 is presented abandons the dump.
        ready_mode = 0;
        fill_rf(1);
        start_dump(TEST_PC);
        g = 0;
        while (!(out_valid && out_tag == 7) && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("rst_tag7_seen", out_tag, 7);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tag", out_tag, 0);
        check("midrst_last", out_last, 0);
        #1 reset = 1'b0;
        repeat (45) @(negedge clk);
        check("midrst_no_done", done_count, 0);
        check("midrst_idle", busy, 0);
        start_dump(TEST_PC);
        wait_done(n);
        check("restart_cycles", n, FULL_CYC);
        post_done(1);
        build_expected(TEST_PC, 1);
        compare_stream();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regdump_streamer.md
Name: regdump_streamer

Overview:
Debug block that, on request, snapshots the CPU's PC and walks the register file's observed set in fixed order: $s0-$s7, then $t0-$t9. It emits each word as a valid/ready stream to an external consumer such as a UART, trace buffer or checker. It is the producing end of the register-observation interface. It attaches to a spare asynchronous read port of the pipeline register file, beside the pipeline top.

Parameters:
DATA_W, 32, width of PC, register and stream data words
ADDR_W, 5, register-file address width
TAG_W, 5, width of the word-index tag on the stream

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
dump_req  input  1  start a dump; sampled only in IDLE
pc_in  input  DATA_W  current PC; captured in the cycle dump_req is accepted
rf_raddr  output  ADDR_W  register-file read address
rf_rdata  input  DATA_W  register-file read data, combinational from rf_raddr
out_valid  output  1  stream word valid
out_ready  input  1  consumer accepts word
out_data  output  DATA_W  stream word
out_tag  output  TAG_W  word index: 0=PC, 1-8=$s0-$s7, 9-18=$t0-$t9, 19=checksum
out_last  output  1  high with the final word of a dump
busy  output  1  dump in progress (any state except IDLE)
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid, out_last, busy and done = 0; out_data, out_tag and rf_raddr = 0; idx=0; checksum accumulator=0.
- States: IDLE, SEND_PC, FETCH, SEND_REG, DONE.
- IDLE:
  - If dump_req=1: capture pc_in into out_data, set out_tag=0 and out_valid=1, clear the accumulator, go to SEND_PC.
  - Latency from dump_req to first valid is 1 cycle.
- SEND_PC: hold out_data, out_tag and out_valid until out_ready=1. On acceptance: idx=1, go to FETCH, drop out_valid.
- FETCH:
  - Drive rf_raddr = map(idx). Map: idx 1-8 gives 16-23; idx 9-16 gives 8-15; idx 17-18 gives 24-25.
  - At the clock edge, register rf_rdata into out_data, set out_tag=idx, set out_valid=1, go to SEND_REG.
- SEND_REG:
  - rf_raddr holds its value.
  - out_data, out_tag and out_last must stay stable while out_valid=1 and out_ready=0.
  - On acceptance with idx<18: idx+1, go to FETCH.
  - On acceptance with idx=18 (last word): go to DONE.
- out_last = 1 only while the final word is presented.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE.
- Throughput: minimum 2 cycles per register word (FETCH plus accept). A dump with out_ready held high takes 38 cycles from the dump_req edge to the done pulse.
- Accumulator: XOR of every accepted word, updated on each out_valid&&out_ready.
- dump_req while busy is ignored and does not queue. dump_req high in the same cycle as the DONE state is ignored.
- Register values are sampled at FETCH time, not at request time. Writes by the pipeline during a dump are visible for registers not yet fetched.
- Reset asserted mid-dump: at the next edge all state returns to reset values. out_valid drops without completing the handshake, no done pulse is produced, and the partial dump is abandoned.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro REGDUMP_CHECKSUM_EN.
- When defined:
  - After $t9 is accepted, the FSM enters SEND_SUM, presenting out_data = XOR of the 19 prior words, out_tag=19, out_last=1.
  - $t9 is not flagged last.
  - done pulses after the checksum is accepted.
  - Dump length is 20 words; full-rate dump takes 39 cycles to done.
- When undefined: no SEND_SUM state and no accumulator logic; $t9 carries out_last.

Test Plan:
- Reg r16-r25 and r8-r15 preloaded with 0x100+r, pc_in=0x0040_0020, out_ready=1, pulse dump_req. Required: 19 words in order 0x00400020, 0x110..0x117, 0x108..0x10F, 0x118, 0x119; tags 0-18; out_last only on tag 18; done exactly once, 38 cycles after the request edge.
- Same stimulus, out_ready toggled 1-of-3 cycles. Required: identical word and tag sequence, no drops or duplicates, out_data and out_tag stable while stalled.
- dump_req held high for 50 cycles. Required: exactly one dump, then a second dump starts the cycle after DONE returns to IDLE.
- reset asserted on the cycle tag 7 is presented. Required: next cycle out_valid=0, busy=0, done never pulses; a new dump_req restarts at tag 0.
- Register write to r17 (0xDEAD_BEEF) while idx=1. Required: tag 2 carries 0xDEADBEEF.
- REGDUMP_CHECKSUM_EN defined, first scenario's data. Required: 20th word tag 19 equals the XOR of the preceding 19 words, with out_last set on it only.
